// File: rtl/serial_fifo_controller.sv
// Full-duplex UART-style controller with parametrised word width, bit period and parity,
// buffered by independent TX and RX FIFOs.
module serial_fifo_controller #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Send,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Read,
  input  logic             Receive,
  output logic             Transmit,
  output logic             Valid,
  output logic [WIDTH-1:0] DataOut,
  output logic             TxFull,
  output logic             RxOverrun,
  output logic             ParityError,
  output logic             FrameError
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [KW-1:0] BIT_END  = KW'(CLKS_PER_BIT - 1);
  localparam logic [KW-1:0] HALF_END = KW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit            HAS_PAR  = (PARITY != 0);
  localparam bit            ODD_PAR  = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [PW-1:0]    tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0]    tx_count, tx_count_nx;
  logic             tx_push, tx_pop, tx_avail;
  logic [WIDTH-1:0] tx_head;

  assign tx_head     = tx_mem[tx_rd_ptr];
  assign tx_avail    = (tx_count != '0);
  // A word offered while full still fits if the FSM frees a slot on the same edge.
  assign tx_push     = Send && (!TxFull || tx_pop);
  assign tx_count_nx = tx_count + CW'(tx_push) - CW'(tx_pop);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      TxFull    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count_nx;
      TxFull   <= (tx_count_nx == FULL_CNT);
    end
  end

  // NOTE: storage arrays carry no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge Clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= DataIn;
  end

  // ---------------------------------------------------------------- TX FSM
  state_t           tx_state, tx_state_nx;
  logic [KW-1:0]    tx_clk, tx_clk_nx;
  logic [BW-1:0]    tx_bit, tx_bit_nx;
  logic [WIDTH-1:0] tx_shift, tx_shift_nx;
  logic             tx_par, tx_par_nx, tx_line_nx, tx_load;

  // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
  always_comb begin
    tx_state_nx = tx_state;
    tx_clk_nx   = tx_clk;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_par_nx   = tx_par;
    tx_load     = 1'b0;
    tx_pop      = 1'b0;
    tx_line_nx  = 1'b1;

    case (tx_state)
      S_IDLE:  tx_load = tx_avail;
      default: begin
        if (tx_clk != BIT_END) begin
          tx_clk_nx = tx_clk + 1'b1;
        end else begin
          tx_clk_nx = '0;
          case (tx_state)
            S_START:  tx_state_nx = S_DATA;
            S_DATA: begin
              tx_shift_nx = tx_shift >> 1;
              if (tx_bit == LAST_BIT) tx_state_nx = HAS_PAR ? S_PARITY : S_STOP;
              else                    tx_bit_nx   = tx_bit + 1'b1;
            end
            S_PARITY: tx_state_nx = S_STOP;
            default: begin
              tx_state_nx = S_IDLE;
              tx_load     = tx_avail;
            end
          endcase
        end
      end
    endcase

    // Loading from STOP chains the next frame straight into START with no idle cycle.
    if (tx_load) begin
      tx_pop      = 1'b1;
      tx_shift_nx = tx_head;
      tx_par_nx   = (^tx_head) ^ ODD_PAR;
      tx_state_nx = S_START;
      tx_clk_nx   = '0;
      tx_bit_nx   = '0;
    end

    case (tx_state)
      S_START:  tx_line_nx = 1'b0;
      S_DATA:   tx_line_nx = tx_shift[0];
      S_PARITY: tx_line_nx = tx_par;
      default:  tx_line_nx = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_state <= S_IDLE;
      tx_clk   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      Transmit <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_clk   <= tx_clk_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
      tx_par   <= tx_par_nx;
      Transmit <= tx_line_nx;
    end
  end

  // ---------------------------------------------------------------- RX synchroniser
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Receive;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;

  // ---------------------------------------------------------------- RX FSM
  state_t           rx_state, rx_state_nx;
  logic [KW-1:0]    rx_clk, rx_clk_nx;
  logic [BW-1:0]    rx_bit, rx_bit_nx;
  logic [WIDTH-1:0] rx_shift, rx_shift_nx;
  logic             rx_par_bit, rx_par_bit_nx;
  logic             rx_word_done, frame_err_nx, parity_err_nx;

  always_comb begin
    rx_state_nx   = rx_state;
    rx_clk_nx     = rx_clk;
    rx_bit_nx     = rx_bit;
    rx_shift_nx   = rx_shift;
    rx_par_bit_nx = rx_par_bit;
    rx_word_done  = 1'b0;
    frame_err_nx  = 1'b0;
    parity_err_nx = 1'b0;

    case (rx_state)
      S_IDLE: begin
        if (rx_fall) begin
          rx_state_nx = S_START;
          rx_clk_nx   = '0;
        end
      end
      S_START: begin
        if (rx_clk != HALF_END) begin
          rx_clk_nx = rx_clk + 1'b1;
        end else begin
          rx_clk_nx = '0;
          rx_bit_nx = '0;
          // Line back high at mid-start means a glitch, not a frame.
          rx_state_nx = rx_sync ? S_IDLE : S_DATA;
        end
      end
      default: begin
        if (rx_clk != BIT_END) begin
          rx_clk_nx = rx_clk + 1'b1;
        end else begin
          rx_clk_nx = '0;
          case (rx_state)
            S_DATA: begin
              rx_shift_nx[rx_bit] = rx_sync;
              if (rx_bit == LAST_BIT) rx_state_nx = HAS_PAR ? S_PARITY : S_STOP;
              else                    rx_bit_nx   = rx_bit + 1'b1;
            end
            S_PARITY: begin
              rx_par_bit_nx = rx_sync;
              rx_state_nx   = S_STOP;
            end
            default: begin
              rx_state_nx = S_IDLE;
              if (!rx_sync) begin
                frame_err_nx = 1'b1;
              end else begin
                rx_word_done  = 1'b1;
                parity_err_nx = HAS_PAR && (((^rx_shift) ^ ODD_PAR) != rx_par_bit);
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_state   <= S_IDLE;
      rx_clk     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      rx_state   <= rx_state_nx;
      rx_clk     <= rx_clk_nx;
      rx_bit     <= rx_bit_nx;
      rx_shift   <= rx_shift_nx;
      rx_par_bit <= rx_par_bit_nx;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0]    rx_wr_ptr, rx_rd_ptr, rx_rd_nx;
  logic [CW-1:0]    rx_count, rx_left, rx_count_nx;
  logic             rx_pop, rx_push, rx_full;

  assign rx_full     = (rx_count == FULL_CNT);
  assign rx_pop      = Read && Valid;
  assign rx_push     = rx_word_done && (!rx_full || rx_pop);
  assign rx_left     = rx_count - CW'(rx_pop);
  assign rx_count_nx = rx_left + CW'(rx_push);
  assign rx_rd_nx    = rx_rd_ptr + PW'(rx_pop);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      Valid       <= 1'b0;
      DataOut     <= '0;
      RxOverrun   <= 1'b0;
      ParityError <= 1'b0;
      FrameError  <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      rx_rd_ptr   <= rx_rd_nx;
      rx_count    <= rx_count_nx;
      Valid       <= (rx_count_nx != '0);
      RxOverrun   <= rx_word_done && rx_full && !rx_pop;
      ParityError <= parity_err_nx;
      FrameError  <= frame_err_nx;
      // Show-ahead head: the incoming word when the FIFO drains to it, else the next stored entry.
      if (rx_left == '0) begin
        if (rx_push) DataOut <= rx_shift;
      end else if (rx_pop) begin
        DataOut <= rx_mem[rx_rd_nx];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

endmodule
